// File: rtl/uart_autobaud_ctrl.sv
`default_nettype none
// ============================================================================
// Module : uart_autobaud_ctrl
// Holds the UART receiver in reset, times a 0x55 sync character on RXD and
// derives the receiver sample_width (sample period in clocks minus one).
// Rev    : 1.0  initial release
// ============================================================================
module uart_autobaud_ctrl #(
  parameter int                           SAMPLE_WIDTH_BITS = 15,
  parameter int                           SAMPLE_BITS       = 5,
  parameter int                           CNT_BITS          = 24,
  parameter logic [SAMPLE_WIDTH_BITS-1:0] DEFAULT_WIDTH     = 15'd433,
  parameter int                           IDLE_CYCLES       = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         RXD,
  output logic [SAMPLE_WIDTH_BITS-1:0] sample_width,
  output logic                         rcv_nRst,
  output logic                         busy,
  output logic                         locked,
  output logic                         error
);

  localparam int c_HI_W  = $clog2(IDLE_CYCLES + 1);
  localparam int c_DIV_W = $clog2(CNT_BITS);
  localparam int c_CMP_W = (CNT_BITS > SAMPLE_WIDTH_BITS) ? CNT_BITS + 1 : SAMPLE_WIDTH_BITS + 2;

  localparam logic [CNT_BITS:0]    c_DIVISOR  = (CNT_BITS+1)'(8 * SAMPLE_BITS);
  localparam logic [CNT_BITS:0]    c_ROUND    = (CNT_BITS+1)'(4 * SAMPLE_BITS);
  localparam logic [CNT_BITS:0]    c_ONE_N    = (CNT_BITS+1)'(1);
  localparam logic [c_HI_W-1:0]    c_HI_LAST  = c_HI_W'(IDLE_CYCLES - 1);
  localparam logic [c_DIV_W-1:0]   c_DIV_LAST = c_DIV_W'(CNT_BITS - 1);
  localparam logic [c_CMP_W-1:0]   c_ONE_CMP  = c_CMP_W'(1);
  localparam logic [c_CMP_W-1:0]   c_Q_MAX    = c_ONE_CMP << SAMPLE_WIDTH_BITS;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_HIGH  = 3'd1,
    S_WAIT_START = 3'd2,
    S_MEASURE    = 3'd3,
    S_DIVIDE     = 3'd4,
    S_CHECK      = 3'd5
  } state_t;

  state_t                         r_state;
  state_t                         w_next;
  logic                           w_busy;

  logic                           r_rx_meta;
  logic                           r_rxs;
  logic                           r_rxs_d;

  logic [c_HI_W-1:0]              r_hi_cnt;
  logic [CNT_BITS-1:0]            r_t;
  logic [1:0]                     r_edges;
  logic [c_DIV_W-1:0]             r_div_cnt;
  logic [CNT_BITS-1:0]            r_num;
  logic [CNT_BITS-1:0]            r_rem;
  logic [CNT_BITS-1:0]            r_quo;
  logic [SAMPLE_WIDTH_BITS-1:0]   r_sw;
  logic                           r_locked;
  logic                           r_error;

  logic                           w_fall;
  logic                           w_hi_done;
  logic                           w_t_sat;
  logic                           w_last_edge;
  logic                           w_div_done;
  logic [CNT_BITS:0]              w_n;
  logic [CNT_BITS:0]              w_trial;
  logic                           w_ge;
  logic [CNT_BITS-1:0]            w_rem_next;
  logic [c_CMP_W-1:0]             w_q_ext;
  logic                           w_bad;
  logic [SAMPLE_WIDTH_BITS-1:0]   w_sw_new;

  assign w_fall      = r_rxs_d & ~r_rxs;
  assign w_hi_done   = r_rxs && (r_hi_cnt == c_HI_LAST);
  assign w_t_sat     = (r_t == '1);
  assign w_last_edge = w_fall && (r_edges == 2'd3);
  assign w_div_done  = (r_div_cnt == c_DIV_LAST);

  // Period count includes the closing edge cycle; half the divisor is added to round.
  assign w_n        = {1'b0, r_t} + c_ONE_N + c_ROUND;

  assign w_trial    = {r_rem, r_num[CNT_BITS-1]};
  assign w_ge       = (w_trial >= c_DIVISOR);
  assign w_rem_next = w_ge ? CNT_BITS'(w_trial - c_DIVISOR) : w_trial[CNT_BITS-1:0];

  assign w_q_ext    = {{(c_CMP_W-CNT_BITS){1'b0}}, r_quo};
  assign w_bad      = (r_quo == '0) || (w_q_ext > c_Q_MAX);
  assign w_sw_new   = SAMPLE_WIDTH_BITS'(w_q_ext - c_ONE_CMP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = S_WAIT_HIGH;
      end
      S_WAIT_HIGH:  if (w_hi_done) w_next = S_WAIT_START;
      S_WAIT_START: if (w_fall)    w_next = S_MEASURE;
      S_MEASURE: begin
        if (w_t_sat)          w_next = S_IDLE;
        else if (w_last_edge) w_next = S_DIVIDE;
      end
      S_DIVIDE:     if (w_div_done) w_next = S_CHECK;
      S_CHECK:      w_next = S_IDLE;
      default: begin
        w_next = S_IDLE;
        w_busy = 1'b0;
      end
    endcase
  end

  // Two-flop synchroniser; idles high like the serial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
      r_rxs_d   <= 1'b1;
    end else begin
      r_rx_meta <= RXD;
      r_rxs     <= r_rx_meta;
      r_rxs_d   <= r_rxs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi_cnt  <= '0;
      r_t       <= '0;
      r_edges   <= '0;
      r_div_cnt <= '0;
      r_num     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_sw      <= DEFAULT_WIDTH;
      r_locked  <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_locked <= 1'b0;
            r_error  <= 1'b0;
            r_hi_cnt <= '0;
          end
        end
        S_WAIT_HIGH: begin
          r_hi_cnt <= r_rxs ? (r_hi_cnt + c_HI_W'(1)) : '0;
        end
        S_WAIT_START: begin
          if (w_fall) begin
            r_t     <= '0;
            r_edges <= '0;
          end
        end
        S_MEASURE: begin
          r_t <= r_t + CNT_BITS'(1);
          if (w_fall) r_edges <= r_edges + 2'd1;
          if (w_t_sat) begin
            r_error <= 1'b1;
          end else if (w_last_edge) begin
            // Numerator MSB seeds the remainder so CNT_BITS steps cover CNT_BITS+1 bits.
            r_num     <= w_n[CNT_BITS-1:0];
            r_rem     <= {{(CNT_BITS-1){1'b0}}, w_n[CNT_BITS]};
            r_quo     <= '0;
            r_div_cnt <= '0;
          end
        end
        S_DIVIDE: begin
          r_rem     <= w_rem_next;
          r_num     <= {r_num[CNT_BITS-2:0], 1'b0};
          r_quo     <= {r_quo[CNT_BITS-2:0], w_ge};
          r_div_cnt <= r_div_cnt + c_DIV_W'(1);
        end
        S_CHECK: begin
          if (w_bad) begin
            r_error <= 1'b1;
          end else begin
            r_sw     <= w_sw_new;
            r_locked <= 1'b1;
          end
        end
        default: begin
          r_hi_cnt <= '0;
        end
      endcase
    end
  end

  assign sample_width = r_sw;
  assign busy         = w_busy;
  assign rcv_nRst     = ~w_busy;
  assign locked       = r_locked;
  assign error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_autobaud_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_autobaud_ctrl
// Directed self-checking bench for uart_autobaud_ctrl (CNT_BITS reduced to 14).
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_autobaud_ctrl;

  localparam int SWB = 15;
  localparam int CNT = 14;
  localparam int LAT = CNT + 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           RXD;
  logic [SWB-1:0] sample_width;
  logic           rcv_nRst;
  logic           busy;
  logic           locked;
  logic           error;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   t_lock   = 0;
  int   t_nrst   = 0;
  int   t_d7     = 0;
  logic locked_q = 1'b0;
  logic nrst_q   = 1'b1;

  uart_autobaud_ctrl #(.CNT_BITS(CNT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .RXD          (RXD),
    .sample_width (sample_width),
    .rcv_nRst     (rcv_nRst),
    .busy         (busy),
    .locked       (locked),
    .error        (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (locked && !locked_q) t_lock <= cyc;
    if (rcv_nRst && !nrst_q) t_nrst <= cyc;
    locked_q <= locked;
    nrst_q   <= rcv_nRst;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // 0x55 frame LSB first: start, d0..d7, stop
  task automatic send_sync(input int p, input int nbits);
    logic [9:0] frame;
    frame = 10'b1010101010;
    for (int i = 0; i < nbits; i++) begin
      RXD = frame[i];
      if (i == 8) t_d7 = cyc;
      tick(p);
    end
    RXD = 1'b1;
  endtask

  task automatic wait_idle(input int bound, output int n);
    n = 0;
    while (busy && n < bound) begin
      tick(1);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; RXD = 1'b1;
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      checks++;
      if ({sample_width, rcv_nRst, busy, locked, error} !== {15'd433, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: got sw=%0d nrst=%b busy=%b lock=%b err=%b expected sw=433 nrst=1 busy=0 lock=0 err=0",
                 i, sample_width, rcv_nRst, busy, locked, error);
      end
    end
  endtask

  task automatic test_clean_lock();
    int n;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || rcv_nRst !== 1'b0) begin
      failures++;
      $display("FAIL clean_busy_on: got busy=%b nrst=%b expected busy=1 nrst=0", busy, rcv_nRst);
    end
    tick(100);
    send_sync(80, 10);
    wait_idle(200, n);
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL clean_timeout: got busy=%b expected busy=0", busy);
    end
    checks++;
    if (sample_width !== 15'd15) begin
      failures++;
      $display("FAIL clean_sw: got %0d expected 15", sample_width);
    end
    checks++;
    if (locked !== 1'b1 || error !== 1'b0 || rcv_nRst !== 1'b1) begin
      failures++;
      $display("FAIL clean_flags: got lock=%b err=%b nrst=%b expected lock=1 err=0 nrst=1", locked, error, rcv_nRst);
    end
    checks++;
    if (t_lock - t_d7 !== LAT) begin
      failures++;
      $display("FAIL clean_lock_latency: got %0d expected %0d", t_lock - t_d7, LAT);
    end
    checks++;
    if (t_nrst - t_d7 !== LAT) begin
      failures++;
      $display("FAIL clean_nrst_latency: got %0d expected %0d", t_nrst - t_d7, LAT);
    end
  endtask

  task automatic test_rounding();
    int periods [2];
    int n;
    periods = '{83, 87};
    for (int k = 0; k < 2; k++) begin
      pulse_start();
      tick(100);
      send_sync(periods[k], 10);
      wait_idle(200, n);
      checks++;
      if (sample_width !== 15'd16 || locked !== 1'b1 || error !== 1'b0 || n >= 200) begin
        failures++;
        $display("FAIL rounding_p%0d: got sw=%0d lock=%b err=%b busy=%b expected sw=16 lock=1 err=0 busy=0",
                 periods[k], sample_width, locked, error, busy);
      end
    end
  endtask

  task automatic test_too_fast();
    int n;
    pulse_start();
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL fast_start_clears_lock: got %b expected 0", locked);
    end
    tick(100);
    send_sync(2, 10);
    wait_idle(200, n);
    checks++;
    if (error !== 1'b1 || locked !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL fast_flags: got err=%b lock=%b busy=%b expected err=1 lock=0 busy=0", error, locked, busy);
    end
    checks++;
    if (sample_width !== 15'd16) begin
      failures++;
      $display("FAIL fast_sw_kept: got %0d expected 16", sample_width);
    end
  endtask

  task automatic test_stuck_low();
    int n;
    int t0;
    pulse_start();
    tick(100);
    RXD = 1'b0;
    t0 = cyc;
    tick(50);
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL stuck_busy_mid: got %b expected 1", busy);
    end
    wait_idle(20000, n);
    checks++;
    if (cyc - t0 !== (1 << CNT) + 3) begin
      failures++;
      $display("FAIL stuck_timeout_cycles: got %0d expected %0d", cyc - t0, (1 << CNT) + 3);
    end
    checks++;
    if (error !== 1'b1 || locked !== 1'b0 || busy !== 1'b0 || rcv_nRst !== 1'b1) begin
      failures++;
      $display("FAIL stuck_flags: got err=%b lock=%b busy=%b nrst=%b expected err=1 lock=0 busy=0 nrst=1",
               error, locked, busy, rcv_nRst);
    end
    checks++;
    if (sample_width !== 15'd16) begin
      failures++;
      $display("FAIL stuck_sw_kept: got %0d expected 16", sample_width);
    end
    RXD = 1'b1;
    tick(5);
  endtask

  task automatic test_reset_mid_measure();
    int n;
    pulse_start();
    tick(100);
    send_sync(40, 4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({sample_width, rcv_nRst, busy, locked, error} !== {15'd433, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midrst_state: got sw=%0d nrst=%b busy=%b lock=%b err=%b expected sw=433 nrst=1 busy=0 lock=0 err=0",
               sample_width, rcv_nRst, busy, locked, error);
    end
    start = 1'b1;
    rst   = 1'b1;
    tick(1);
    start = 1'b0;
    rst   = 1'b0;
    tick(1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_beats_start: got busy=%b expected 0", busy);
    end
    pulse_start();
    tick(100);
    send_sync(40, 10);
    wait_idle(200, n);
    checks++;
    if (sample_width !== 15'd7 || locked !== 1'b1 || error !== 1'b0 || n >= 200) begin
      failures++;
      $display("FAIL midrst_relock: got sw=%0d lock=%b err=%b busy=%b expected sw=7 lock=1 err=0 busy=0",
               sample_width, locked, error, busy);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    RXD   = 1'b1;
    test_reset();
    test_clean_lock();
    test_rounding();
    test_too_fast();
    test_stuck_low();
    test_reset_mid_measure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
